// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the instruction-memory responder.
package rv32i_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } imem_state_e;
endpackage

// File: rtl/instr_mem_array.sv
// Simple dual-port instruction RAM: synchronous write, combinational read.
// A same-word write and read in one cycle sees the old word.
module instr_mem_array
    import rv32i_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic            clock,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [XLEN-1:0] rdata_o
);
    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // The consumer registers this on the same edge as any write lands.
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: one outstanding fetch, fixed read latency,
// valid/ready response with error-tagged NOP for bad addresses.
module instr_mem_responder
    import rv32i_pkg::*;
#(
    parameter int               DEPTH_WORDS  = 1024,
    parameter int               READ_LATENCY = 2,
    parameter logic [XLEN-1:0]  BASE_ADDR    = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            instr_mem_request_i,
    input  logic [XLEN-1:0] instr_mem_address_i,
    output logic            instr_mem_ready_o,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_instr_o,
    output logic            rsp_error_o,
    input  logic            prog_we_i,
    input  logic [XLEN-1:0] prog_addr_i,
    input  logic [XLEN-1:0] prog_wdata_i
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [1:0] LAT_INIT = (READ_LATENCY > 2) ? 2'(READ_LATENCY - 2) : 2'd0;

    imem_state_e     state_q;
    logic [1:0]      lat_cnt_q;
    logic            ready_q;
    logic            valid_q;
    logic [XLEN-1:0] instr_q;
    logic            err_q;

    // 33-bit subtraction: the top bit is the borrow, i.e. address below base.
    logic [XLEN:0]   rd_diff;
    logic [XLEN:0]   wr_diff;
    logic            rd_err;
    logic            wr_ok;
    logic [AW-1:0]   rd_idx;
    logic [AW-1:0]   wr_idx;
    logic [XLEN-1:0] ram_rdata;
    logic            unused_wr_lsb;

    assign rd_diff = {1'b0, instr_mem_address_i} - {1'b0, BASE_ADDR};
    assign wr_diff = {1'b0, prog_addr_i} - {1'b0, BASE_ADDR};
    assign rd_idx  = rd_diff[AW+1:2];
    assign wr_idx  = wr_diff[AW+1:2];

    assign rd_err = rd_diff[XLEN] | (|rd_diff[1:0]) | (|rd_diff[XLEN-1:AW+2]);
    assign wr_ok  = prog_we_i & ~wr_diff[XLEN] & ~(|wr_diff[XLEN-1:AW+2]);
    assign unused_wr_lsb = ^wr_diff[1:0];

    instr_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clock   (clock),
        .we_i    (wr_ok),
        .waddr_i (wr_idx),
        .wdata_i (prog_wdata_i),
        .raddr_i (rd_idx),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            lat_cnt_q <= 2'd0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            instr_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (instr_mem_request_i) begin
                        instr_q <= rd_err ? NOP_INSTR : ram_rdata;
                        err_q   <= rd_err;
                        ready_q <= 1'b0;
                        if (READ_LATENCY > 1) begin
                            state_q   <= WAIT;
                            lat_cnt_q <= LAT_INIT;
                        end else begin
                            state_q <= RESP;
                            valid_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt_q == 2'd0) begin
                        state_q <= RESP;
                        valid_q <= 1'b1;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        instr_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Captured data sits in instr_q during WAIT; hide it until valid.
    assign instr_mem_ready_o = ready_q;
    assign rsp_valid_o       = valid_q;
    assign rsp_instr_o       = valid_q ? instr_q : '0;
    assign rsp_error_o       = valid_q & err_q;
endmodule

// File: tb/tb_instr_mem_responder.sv
// Three responders (latency 1/2/4, one with a non-zero base) share stimulus;
// a queue-free timestamp model predicts every output every cycle.
module tb_instr_mem_responder;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, req, rsp_rdy, we;
    logic [31:0] addr, waddr, wdata;
    logic        rdy_w [3];
    logic        vld_w [3];
    logic        err_w [3];
    logic [31:0] ins_w [3];

    int n_cmp = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        instr_mem_responder #(
            .DEPTH_WORDS (1024),
            .READ_LATENCY(g == 0 ? 1 : (g == 1 ? 2 : 4)),
            .BASE_ADDR   (g == 2 ? 32'h0000_1000 : 32'h0000_0000)
        ) u_dut (
            .clock              (clock),
            .reset              (reset),
            .instr_mem_request_i(req),
            .instr_mem_address_i(addr),
            .instr_mem_ready_o  (rdy_w[g]),
            .rsp_valid_o        (vld_w[g]),
            .rsp_ready_i        (rsp_rdy),
            .rsp_instr_o        (ins_w[g]),
            .rsp_error_o        (err_w[g]),
            .prog_we_i          (we),
            .prog_addr_i        (waddr),
            .prog_wdata_i       (wdata)
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 2) ? 32'h0000_1000 : 32'h0000_0000;
    endfunction

    function automatic bit is_bad(input int d, input logic [31:0] a);
        logic [31:0] b;
        b = base_of(d);
        if (a[1:0] != 2'b00 || a < b) return 1'b1;
        return ((a - b) >> 2) >= 32'd1024;
    endfunction

    function automatic int idx_of(input int d, input logic [31:0] a);
        return int'((a - base_of(d)) >> 2);
    endfunction

    // Model: a fetch is outstanding from its acceptance cycle until the
    // handshake; it is visible once LATENCY cycles have elapsed.
    bit          pend [3];
    int          acc  [3];
    logic [31:0] edat [3];
    bit          eerr [3];
    logic [31:0] mmem [3][1024];
    int          cyc = 0;

    initial forever begin
        @(posedge clock);
        for (int d = 0; d < 3; d++) begin
            if (reset) pend[d] = 1'b0;
            else if (pend[d] && cyc >= acc[d] + lat_of(d) && rsp_rdy) pend[d] = 1'b0;
            else if (!pend[d] && req) begin
                pend[d] = 1'b1;
                acc[d]  = cyc;
                eerr[d] = is_bad(d, addr);
                edat[d] = eerr[d] ? NOP : mmem[d][idx_of(d, addr)];
            end
        end
        if (we) for (int d = 0; d < 3; d++) begin
            logic [31:0] wa;
            wa = {waddr[31:2], 2'b00};
            if (!is_bad(d, wa)) mmem[d][idx_of(d, wa)] = wdata;
        end
        cyc++;
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t got %h want %h", nm, d, $time, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input int d, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t got %b want %b", nm, d, $time, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clock);
        if (check_en) for (int d = 0; d < 3; d++) begin
            logic ev;
            ev = pend[d] && (cyc >= acc[d] + lat_of(d));
            chk1("m_ready", d, rdy_w[d], !pend[d]);
            chk1("m_valid", d, vld_w[d], ev);
            chk ("m_instr", d, ins_w[d], ev ? edat[d] : 32'h0);
            chk1("m_error", d, err_w[d], ev & eerr[d]);
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (rdy_w[0] && rdy_w[1] && rdy_w[2]) return;
            tick();
        end
        n_cmp++;
        n_fail++;
        $display("FAIL wait_idle timeout t=%0t got busy want ready", $time);
    endtask

    function automatic logic [31:0] pick_addr();
        int r, w;
        r = $urandom_range(0, 9);
        w = $urandom_range(0, 15);
        case (r)
            0, 1, 2, 3: return 32'(4 * w);
            4, 5, 6:    return 32'h1000 + 32'(4 * w);
            7:          return (($urandom_range(0, 1) == 1) ? 32'h1000 : 32'h0) + 32'(4 * w) + 32'($urandom_range(1, 3));
            8:          return 32'h2000 + 32'(4 * w);
            default:    return 32'hFFFF_FFF0;
        endcase
    endfunction

    logic [31:0] pre0 [16];
    logic [31:0] pre2 [16];

    initial begin
        reset = 1'b1; req = 1'b0; addr = '0; rsp_rdy = 1'b1;
        we = 1'b0; waddr = '0; wdata = '0;
        tick(); tick();
        check_en = 1'b1;
        for (int d = 0; d < 3; d++) begin
            chk1("rst_ready", d, rdy_w[d], 1'b1);
            chk1("rst_valid", d, vld_w[d], 1'b0);
            chk ("rst_instr", d, ins_w[d], 32'h0);
            chk1("rst_error", d, err_w[d], 1'b0);
        end
        reset = 1'b0;

        for (int w = 0; w < 16; w++) begin
            pre0[w] = (w == 4) ? 32'h0050_0093 : ((w == 8) ? 32'hAAAA_AAAA : $urandom);
            pre2[w] = $urandom;
            we = 1'b1; waddr = 32'(4 * w); wdata = pre0[w]; tick();
            waddr = 32'h1000 + 32'(4 * w); wdata = pre2[w]; tick();
        end
        we = 1'b0;

        // basic read, plus latency 1 and below-base error on the siblings
        wait_idle();
        req = 1'b1; addr = 32'h10; tick(); req = 1'b0;
        chk1("basic_v_t1", 1, vld_w[1], 1'b0);
        chk1("basic_rdy_t1", 1, rdy_w[1], 1'b0);
        chk1("lat1_v_t1", 0, vld_w[0], 1'b1);
        chk ("lat1_data", 0, ins_w[0], 32'h0050_0093);
        tick();
        chk1("basic_v_t2", 1, vld_w[1], 1'b1);
        chk ("basic_data", 1, ins_w[1], 32'h0050_0093);
        chk1("basic_err", 1, err_w[1], 1'b0);
        tick();
        chk1("basic_rdy_after", 1, rdy_w[1], 1'b1);
        chk1("lat4_v_t3", 2, vld_w[2], 1'b0);
        tick();
        chk1("below_base_v", 2, vld_w[2], 1'b1);
        chk ("below_base_nop", 2, ins_w[2], NOP);
        chk1("below_base_err", 2, err_w[2], 1'b1);

        // misaligned and out of range
        wait_idle();
        req = 1'b1; addr = 32'h12; tick(); req = 1'b0; tick();
        chk ("misalign_nop", 1, ins_w[1], NOP);
        chk1("misalign_err", 1, err_w[1], 1'b1);
        wait_idle();
        req = 1'b1; addr = 32'h1000; tick(); req = 1'b0; tick();
        chk1("oor_v", 1, vld_w[1], 1'b1);
        chk ("oor_nop", 1, ins_w[1], NOP);
        chk1("oor_err", 1, err_w[1], 1'b1);
        tick(); tick();
        chk ("base_word0", 2, ins_w[2], pre2[0]);
        chk1("base_word0_err", 2, err_w[2], 1'b0);

        // back-pressure with a competing request held high
        wait_idle();
        rsp_rdy = 1'b0; req = 1'b1; addr = 32'h14; tick(); addr = 32'h18;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk1("bp_valid", 1, vld_w[1], 1'b1);
            chk ("bp_data", 1, ins_w[1], pre0[5]);
            chk1("bp_ready", 1, rdy_w[1], 1'b0);
        end
        rsp_rdy = 1'b1; req = 1'b0; tick();
        chk1("bp_release_v", 1, vld_w[1], 1'b0);
        chk1("bp_release_rdy", 1, rdy_w[1], 1'b1);

        // read/write collision returns old data
        wait_idle();
        req = 1'b1; addr = 32'h20; we = 1'b1; waddr = 32'h20; wdata = 32'hBBBB_BBBB;
        tick(); req = 1'b0; we = 1'b0; tick();
        chk("coll_old", 1, ins_w[1], 32'hAAAA_AAAA);
        wait_idle();
        req = 1'b1; addr = 32'h20; tick(); req = 1'b0; tick();
        chk("coll_new", 1, ins_w[1], 32'hBBBB_BBBB);

        // reset while waiting
        wait_idle();
        req = 1'b1; addr = 32'h10; tick(); req = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
        chk1("rst_mid_v", 1, vld_w[1], 1'b0);
        chk1("rst_mid_rdy", 1, rdy_w[1], 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("rst_mid_quiet", 1, vld_w[1], 1'b0);
        end

        // latency sweep 1 vs 4
        wait_idle();
        req = 1'b1; addr = 32'h1010; tick(); req = 1'b0;
        chk1("sweep_l1_v", 0, vld_w[0], 1'b1);
        chk1("sweep_l1_err", 0, err_w[0], 1'b1);
        chk1("sweep_l4_v1", 2, vld_w[2], 1'b0);
        tick(); chk1("sweep_l4_v2", 2, vld_w[2], 1'b0);
        tick(); chk1("sweep_l4_v3", 2, vld_w[2], 1'b0);
        tick();
        chk1("sweep_l4_v4", 2, vld_w[2], 1'b1);
        chk ("sweep_l4_data", 2, ins_w[2], pre2[4]);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 199) == 0);
            req     = $urandom_range(0, 1) == 1;
            addr    = pick_addr();
            rsp_rdy = $urandom_range(0, 9) < 7;
            we      = $urandom_range(0, 9) < 3;
            waddr   = pick_addr() | 32'($urandom_range(0, 3));
            wdata   = $urandom;
            tick();
        end
        reset = 1'b0; req = 1'b0; we = 1'b0; rsp_rdy = 1'b1;
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_mem_responder.md
# instr_mem_responder

Responder end of the instruction-fetch interface. It accepts word fetch requests from the fetch unit, reads a local instruction RAM, and returns the instruction after a fixed, parameterised latency through a valid/ready response handshake. A separate program-load write port fills the RAM, and bad addresses return an error-tagged NOP. It sits between the fetch stage and the instruction store in the RV32I core.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two, 16..65536.
- READ_LATENCY, 2: cycles from request acceptance to first `rsp_valid_o`; legal range 1..4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to DEPTH_WORDS*4.
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_mem_request_i  in  1  fetch request valid.
- instr_mem_address_i  in  32  byte address of the requested instruction.
- instr_mem_ready_o  out  1  responder can accept a request this cycle.
- rsp_valid_o  out  1  response data valid.
- rsp_ready_i  in  1  fetch side accepts the response.
- rsp_instr_o  out  32  returned instruction word.
- rsp_error_o  out  1  request was misaligned or out of range.
- prog_we_i  in  1  program-load write enable.
- prog_addr_i  in  32  program-load byte address; bits [1:0] are ignored.
- prog_wdata_i  in  32  program-load write data.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - `instr_mem_ready_o`=1.
  - On `instr_mem_request_i`=1 the request is accepted.
  - The RAM word is sampled into the response register in the acceptance cycle.
  - The error flag is computed and captured in the same cycle.
  - Next state is WAIT if READ_LATENCY>1, otherwise RESP.
- **WAIT**
  - `lat_cnt` is loaded with READ_LATENCY-2 on acceptance and decrements each cycle.
  - Leave for RESP when `lat_cnt`==0.
  - `instr_mem_ready_o`=0.
- **RESP**
  - `rsp_valid_o`=1.
  - `rsp_instr_o` and `rsp_error_o` stay stable until `rsp_ready_i`=1.
  - On that handshake, return to IDLE.
  - `instr_mem_ready_o`=0.
- **Error condition:** `address[1:0]`!=0, or the word index (address-BASE_ADDR)>>2 is ≥ DEPTH_WORDS, or address < BASE_ADDR.
  - On error: `rsp_instr_o`=32'h0000_0013 (NOP) and `rsp_error_o`=1.
  - Error responses have the same latency as good ones.
- **Program-load writes**
  - Accepted in any state, every cycle `prog_we_i`=1.
  - Out-of-range write addresses are dropped silently.
- **Read/write collision:** a write to the same word in the acceptance cycle returns the OLD data (read-before-write). Writes after acceptance do not affect the in-flight response.
- **Response outputs:** when `rsp_valid_o`=0, `rsp_instr_o`=0 and `rsp_error_o`=0.
- **Arithmetic:** word index uses bits [$clog2(DEPTH_WORDS)+1:2] of (address-BASE_ADDR). The subtraction is 32-bit unsigned, and the borrow signals address < BASE_ADDR.

## Timing
- **Reset values** (in the cycle after `reset` is sampled high):
  - state=IDLE, `instr_mem_ready_o`=1, `rsp_valid_o`=0, `rsp_instr_o`=0, `rsp_error_o`=0, `lat_cnt`=0.
  - RAM contents are not reset.
- **Latency:** request accepted at edge T gives `rsp_valid_o`=1 from cycle T+READ_LATENCY.
- **Throughput:** at most one request per READ_LATENCY+1 cycles when `rsp_ready_i` is held at 1.
- **Handshake:**
  - A request is accepted only on `instr_mem_request_i` && `instr_mem_ready_o`.
  - A response completes on `rsp_valid_o` && `rsp_ready_i`.
  - `rsp_valid_o` never drops before the handshake completes.
- **Back-pressure:** with `rsp_ready_i`=0 the FSM stays in RESP indefinitely and new requests are not accepted.
- **Reset mid-operation:** any in-flight or pending response is discarded; no response is produced for it after reset.
- **Simultaneous reset and write:** reset wins for control state; the RAM write still occurs.

## Structure
- Shared package `rv32i_pkg` holds:
  - XLEN=32.
  - NOP_INSTR=32'h0000_0013.
  - The enum `imem_state_e` {IDLE, WAIT, RESP}.
- Sub-module `instr_mem_array`:
  - Simple dual-port RAM with one synchronous-write port and one read port.
  - Read-before-write on a same-address collision.
  - Parameterised by DEPTH_WORDS.
- The top level holds the FSM, latency counter, address check and response registers.

## Test plan
- **Basic read:** preload word 4 (byte 0x10) with 0x0050_0093; request 0x10 with READ_LATENCY=2 and `rsp_ready_i`=1 → `rsp_valid_o` exactly 2 cycles after acceptance, `rsp_instr_o`=0x0050_0093, `rsp_error_o`=0, `instr_mem_ready_o`=1 the cycle after the handshake.
- **Misaligned and out-of-range:** request 0x12, then 0x1000 with DEPTH_WORDS=1024 → both return 0x0000_0013 with `rsp_error_o`=1 at normal latency.
- **Back-pressure:** hold `rsp_ready_i`=0 for 5 cycles → `rsp_valid_o` and data stable throughout, `instr_mem_ready_o`=0, a new request is not accepted; release → handshake, then IDLE.
- **Collision:** word 8 holds 0xAAAA_AAAA; in the acceptance cycle of a read of 0x20, write 0xBBBB_BBBB to 0x20 → response 0xAAAA_AAAA; a second read → 0xBBBB_BBBB.
- **Reset mid-operation:** assert `reset` for 1 cycle while in WAIT → next cycle `rsp_valid_o`=0, `instr_mem_ready_o`=1, no response emerges for the aborted request.
- **Latency sweep:** READ_LATENCY=1 and READ_LATENCY=4 → valid at T+1 and T+4 respectively, with no WAIT state visited when READ_LATENCY=1.
